inv_stim_checker: RTL and testbench
===================================

// Module: inv_stim_checker
// PURPOSE
//   Self-checking stimulus/response engine for inverter-type DUTs, synthesisable and clocked.
//   Drives NUM_VEC vectors of a selectable pattern onto a WIDTH-bit DUT input, holding each for HOLD cycles.
//   Samples the DUT response LAT cycles into each vector, checks it against ~stim, and counts mismatches.
//   Sits between a bench/top controller (start/done) and the DUT under test.
// PARAMETERS
//   WIDTH    1   DUT data width (stim/resp), >=1
//   HOLD     10  clock cycles each vector is held, >=1
//   NUM_VEC  9   number of vectors per run, >=1
//   LAT      0   DUT response latency in cycles, 0..HOLD-1
//   ERRW     8   width of the mismatch counter
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active-high
//   start    in   1      begin a run (sampled only in IDLE or DONE)
//   mode     in   2      pattern: 00 toggle, 01 walking-one, 10 binary count, 11 walking-zero
//   stim     out  WIDTH  drive to DUT input (registered)
//   resp     in   WIDTH  DUT output
//   busy     out  1      high while in RUN
//   done     out  1      high while in DONE
//   vec_idx  out  $clog2(NUM_VEC+1)  index of the current vector
//   err_cnt  out  ERRW   saturating mismatch count for current/last run
//   err_flag out  1      sticky: at least one mismatch this run
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; stim=0, busy=0, done=0, vec_idx=0, err_cnt=0, err_flag=0, hold_cnt=0.
//   FSM: IDLE -start-> RUN; RUN -last vector complete-> DONE; DONE -start-> RUN.
//   start while in RUN is ignored; mode is latched on the accepted start and ignored afterwards.
//   On accept (edge with start=1 in IDLE/DONE): next cycle state=RUN, busy=1, done=0,
//     vec_idx=0, hold_cnt=0, err_cnt=0, err_flag=0, stim=initial pattern.
//   Initial pattern: toggle 0; walking-one {0..,1}; count 0; walking-zero ~{0..,1}.
//   Next pattern: toggle ~stim; walking-one/zero rotate-left by 1; count stim+1 mod 2^WIDTH.
//   Vector timing: hold_cnt counts 0..HOLD-1. At the edge ending hold_cnt==HOLD-1:
//     - if vec_idx==NUM_VEC-1: state=DONE, busy=0, done=1, stim holds last value;
//     - otherwise: vec_idx+1, next pattern, hold_cnt=0.
//   A run therefore keeps busy high for exactly NUM_VEC*HOLD cycles.
//   Check: at the edge ending hold_cnt==LAT, if resp != ~stim then err_cnt+1
//     (saturates at 2^ERRW-1, no wrap) and err_flag=1. There is exactly one check per vector.
//   With LAT=0 the check covers a combinational DUT in the vector's first cycle.
//   The check on the last vector still occurs when HOLD==1 (check and advance share the same edge).
//   In DONE, err_cnt, err_flag, vec_idx and stim hold until the next accepted start or reset.
//   Reset mid-run aborts the run immediately; no partial results are retained.
//   WIDTH==1 walking patterns degenerate: walking-one is constant 1 and walking-zero is constant 0.
// TESTING
//   1 WIDTH=1,HOLD=10,NUM_VEC=9, mode 00, DUT=inverter, start -> stim 0,1,0,..,0 every 10 clk; done after 90 clk; err_cnt=0, err_flag=0
//   2 Same setup with DUT=buffer (resp=stim) -> err_cnt=9, err_flag=1 at done
//   3 WIDTH=4,NUM_VEC=6, mode 01 -> stim 0001,0010,0100,1000,0001,0010; mode 11 -> 1110,1101,1011,0111,1110,1101
//   4 WIDTH=2,NUM_VEC=6, mode 10 -> stim 0,1,2,3,0,1 (count wraps); ERRW=2 with buffer DUT -> err_cnt saturates at 3
//   5 LAT=3 with DUT=3-stage registered inverter -> err_cnt=0; same DUT with LAT=0 -> err_cnt=NUM_VEC
//   6 start pulsed mid-RUN -> no effect; rst at vec_idx=4 -> all outputs 0/IDLE immediately; restart runs a full 9 vectors

Source files
------------

// File: rtl/inv_stim_checker.sv
// inv_stim_checker: clocked stimulus/response engine for inverter-type DUTs.
// Drives NUM_VEC vectors of a selectable pattern onto the DUT input, holds each
// for HOLD cycles, samples the DUT response LAT cycles into each vector and
// counts responses that differ from the bitwise inverse of the stimulus.
module inv_stim_checker #(
    parameter int WIDTH   = 1,
    parameter int HOLD    = 10,
    parameter int NUM_VEC = 9,
    parameter int LAT     = 0,
    parameter int ERRW    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    output logic [WIDTH-1:0]             stim,
    input  logic [WIDTH-1:0]             resp,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_VEC+1)-1:0] vec_idx,
    output logic [ERRW-1:0]              err_cnt,
    output logic                         err_flag
);

    localparam int VEC_W  = $clog2(NUM_VEC + 1);
    // HOLD+1 keeps the counter at least one bit wide when HOLD==1.
    localparam int HOLD_W = $clog2(HOLD + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_WALK1  = 2'b01;
    localparam logic [1:0] MODE_COUNT  = 2'b10;
    localparam logic [1:0] MODE_WALK0  = 2'b11;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0] CHECK_AT  = HOLD_W'(LAT);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VEC - 1);
    localparam logic [ERRW-1:0]   ERR_MAX   = {ERRW{1'b1}};
    localparam logic [WIDTH-1:0]  PAT_ONE   = WIDTH'(1);

    // First vector of a run for the selected pattern.
    function automatic logic [WIDTH-1:0] init_pat(input logic [1:0] m);
        logic [WIDTH-1:0] p;
        p = '0;
        case (m)
            MODE_TOGGLE: p = '0;
            MODE_WALK1:  p = PAT_ONE;
            MODE_COUNT:  p = '0;
            MODE_WALK0:  p = ~PAT_ONE;
            default:     p = '0;
        endcase
        return p;
    endfunction

    // Successor of the current vector. The rotate is written with shifts so a
    // one-bit bus rotates onto itself, leaving walking patterns constant.
    function automatic logic [WIDTH-1:0] next_pat(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] p;
        p = cur;
        case (m)
            MODE_TOGGLE: p = ~cur;
            MODE_WALK1,
            MODE_WALK0:  p = (cur << 1) | (cur >> (WIDTH - 1));
            MODE_COUNT:  p = cur + PAT_ONE;
            default:     p = cur;
        endcase
        return p;
    endfunction

    logic [1:0]        state,    state_d;
    logic [1:0]        mode_q,   mode_d;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic [WIDTH-1:0]  stim_d;
    logic              busy_d, done_d, err_flag_d;
    logic [VEC_W-1:0]  vec_idx_d;
    logic [ERRW-1:0]   err_cnt_d;
    logic              accept;
    logic              check_now;
    logic              mismatch;

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign check_now = (state == ST_RUN) && (hold_cnt == CHECK_AT);
    assign mismatch  = (resp != ~stim);

    // Next-state, pattern sequencing and response checking.
    always_comb begin
        // NOTE: every signal assigned below gets a hold-value default first, so
        // no path through the case statement leaves one unassigned (no latch).
        state_d    = state;
        mode_d     = mode_q;
        hold_cnt_d = hold_cnt;
        stim_d     = stim;
        busy_d     = busy;
        done_d     = done;
        vec_idx_d  = vec_idx;
        err_cnt_d  = err_cnt;
        err_flag_d = err_flag;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d    = ST_RUN;
                    mode_d     = mode;
                    hold_cnt_d = '0;
                    stim_d     = init_pat(mode);
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    vec_idx_d  = '0;
                    err_cnt_d  = '0;
                    err_flag_d = 1'b0;
                end
            end

            ST_RUN: begin
                // One check per vector; it may share its edge with the advance.
                if (check_now && mismatch) begin
                    err_flag_d = 1'b1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt_d = err_cnt + 1'b1;
                    end
                end

                if (hold_cnt == HOLD_LAST) begin
                    if (vec_idx == VEC_LAST) begin
                        // Last vector finished: stim keeps its final value.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        vec_idx_d  = vec_idx + 1'b1;
                        stim_d     = next_pat(mode_q, stim);
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_TOGGLE;
            hold_cnt <= '0;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            vec_idx  <= '0;
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state    <= state_d;
            mode_q   <= mode_d;
            hold_cnt <= hold_cnt_d;
            stim     <= stim_d;
            busy     <= busy_d;
            done     <= done_d;
            vec_idx  <= vec_idx_d;
            err_cnt  <= err_cnt_d;
            err_flag <= err_flag_d;
        end
    end

endmodule

// File: tb/tb_inv_stim_checker.sv
// tb_inv_stim_checker: directed bench for inv_stim_checker. Several parameter
// sets run side by side; expected stimulus values are queued when a run is
// started and popped as each vector appears on the DUT output.
module tb_inv_stim_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [4:0] start_v = '0;
    logic [4:0] bufsel = '0;
    logic [4:0] fault = '0;

    int n_checks = 0;
    int n_errs   = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    // u0: WIDTH=1 HOLD=10 NUM_VEC=9 LAT=0
    logic [0:0] stim0, resp0;
    logic       busy0, done0, ef0;
    logic [3:0] vi0;
    logic [7:0] ec0;
    // u1: WIDTH=4 HOLD=2 NUM_VEC=6
    logic [3:0] stim1, resp1;
    logic       busy1, done1, ef1;
    logic [2:0] vi1;
    logic [7:0] ec1;
    // u2: WIDTH=2 HOLD=1 NUM_VEC=6 ERRW=2
    logic [1:0] stim2, resp2;
    logic       busy2, done2, ef2;
    logic [2:0] vi2;
    logic [1:0] ec2;
    // u3/u4: WIDTH=4 HOLD=5 NUM_VEC=4, 3-stage registered inverter, LAT=3 / LAT=0
    logic [3:0] stim3, resp3, stim4, resp4;
    logic       busy3, done3, ef3, busy4, done4, ef4;
    logic [2:0] vi3, vi4;
    logic [7:0] ec3, ec4;
    logic [3:0] p3a, p3b, p3c, p4a, p4b, p4c;

    // Inverter DUT models, turned into buffers by bufsel or a one-vector fault.
    assign resp0 = (bufsel[0] ^ fault[0]) ? stim0 : ~stim0;
    assign resp1 = (bufsel[1] ^ fault[1]) ? stim1 : ~stim1;
    assign resp2 = (bufsel[2] ^ fault[2]) ? stim2 : ~stim2;
    assign resp3 = p3c;
    assign resp4 = p4c;

    // Three-stage registered inverters.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p3a <= '0; p3b <= '0; p3c <= '0;
            p4a <= '0; p4b <= '0; p4c <= '0;
        end else begin
            p3a <= ~stim3; p3b <= p3a; p3c <= p3b;
            p4a <= ~stim4; p4b <= p4a; p4c <= p4b;
        end
    end

    inv_stim_checker #(.WIDTH(1), .HOLD(10), .NUM_VEC(9), .LAT(0), .ERRW(8)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .stim(stim0), .resp(resp0),
        .busy(busy0), .done(done0), .vec_idx(vi0), .err_cnt(ec0), .err_flag(ef0));
    inv_stim_checker #(.WIDTH(4), .HOLD(2), .NUM_VEC(6), .LAT(0), .ERRW(8)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .stim(stim1), .resp(resp1),
        .busy(busy1), .done(done1), .vec_idx(vi1), .err_cnt(ec1), .err_flag(ef1));
    inv_stim_checker #(.WIDTH(2), .HOLD(1), .NUM_VEC(6), .LAT(0), .ERRW(2)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .stim(stim2), .resp(resp2),
        .busy(busy2), .done(done2), .vec_idx(vi2), .err_cnt(ec2), .err_flag(ef2));
    inv_stim_checker #(.WIDTH(4), .HOLD(5), .NUM_VEC(4), .LAT(3), .ERRW(8)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode), .stim(stim3), .resp(resp3),
        .busy(busy3), .done(done3), .vec_idx(vi3), .err_cnt(ec3), .err_flag(ef3));
    inv_stim_checker #(.WIDTH(4), .HOLD(5), .NUM_VEC(4), .LAT(0), .ERRW(8)) u4 (
        .clk(clk), .rst(rst), .start(start_v[4]), .mode(mode), .stim(stim4), .resp(resp4),
        .busy(busy4), .done(done4), .vec_idx(vi4), .err_cnt(ec4), .err_flag(ef4));

    typedef struct packed {
        logic [3:0] stim;
        logic       busy;
        logic       done;
        logic [3:0] vec_idx;
        logic [7:0] err_cnt;
        logic       err_flag;
    } obs_t;

    // Zero-extended snapshot of one instance's outputs.
    function automatic obs_t observe(input int i);
        obs_t o;
        o = '0;
        case (i)
            0: begin o.stim = {3'b0, stim0}; o.busy = busy0; o.done = done0;
                     o.vec_idx = vi0; o.err_cnt = ec0; o.err_flag = ef0; end
            1: begin o.stim = stim1; o.busy = busy1; o.done = done1;
                     o.vec_idx = {1'b0, vi1}; o.err_cnt = ec1; o.err_flag = ef1; end
            2: begin o.stim = {2'b0, stim2}; o.busy = busy2; o.done = done2;
                     o.vec_idx = {1'b0, vi2}; o.err_cnt = {6'b0, ec2}; o.err_flag = ef2; end
            3: begin o.stim = stim3; o.busy = busy3; o.done = done3;
                     o.vec_idx = {1'b0, vi3}; o.err_cnt = ec3; o.err_flag = ef3; end
            default: begin o.stim = stim4; o.busy = busy4; o.done = done4;
                     o.vec_idx = {1'b0, vi4}; o.err_cnt = ec4; o.err_flag = ef4; end
        endcase
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int i, input string tag);
        obs_t o;
        o = observe(i);
        check({tag, ".stim"},     32'(o.stim),     32'd0);
        check({tag, ".busy"},     32'(o.busy),     32'd0);
        check({tag, ".done"},     32'(o.done),     32'd0);
        check({tag, ".vec_idx"},  32'(o.vec_idx),  32'd0);
        check({tag, ".err_cnt"},  32'(o.err_cnt),  32'd0);
        check({tag, ".err_flag"}, 32'(o.err_flag), 32'd0);
    endtask

    // One run on instance i. mid_v: pulse start (with a new mode) at that vector.
    // abort_v: assert rst at that vector. fault_v: make the DUT a buffer for that vector.
    task automatic run(input int i, input int hold, input int nvec,
                       input int mid_v, input int abort_v, input int fault_v);
        obs_t       o;
        logic [3:0] e;
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
        o = observe(i);
        check($sformatf("u%0d.accept.busy", i),    32'(o.busy),     32'd1);
        check($sformatf("u%0d.accept.done", i),    32'(o.done),     32'd0);
        check($sformatf("u%0d.accept.err_cnt", i), 32'(o.err_cnt),  32'd0);
        check($sformatf("u%0d.accept.err_flag", i), 32'(o.err_flag), 32'd0);
        for (int v = 0; v < nvec; v++) begin
            o = observe(i);
            if (exp_q.size() == 0) begin
                check($sformatf("u%0d.scoreboard_empty", i), 32'd1, 32'd0);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            check($sformatf("u%0d.v%0d.stim", i, v),    32'(o.stim),    32'(e));
            check($sformatf("u%0d.v%0d.vec_idx", i, v), 32'(o.vec_idx), 32'(v));
            if (v == abort_v) begin
                rst = 1'b1;
                #1;
                check_zero(i, $sformatf("u%0d.abort", i));
                tick();
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            fault[i] = (v == fault_v);
            for (int k = 0; k < hold; k++) begin
                if (v == mid_v && k == 0) begin
                    start_v[i] = 1'b1;
                    mode = ~mode;
                end
                if (k == hold - 1) begin
                    o = observe(i);
                    check($sformatf("u%0d.v%0d.busy_end", i, v), 32'(o.busy), 32'd1);
                end
                tick();
                start_v[i] = 1'b0;
            end
            fault[i] = 1'b0;
        end
        o = observe(i);
        check($sformatf("u%0d.end.done", i),    32'(o.done),    32'd1);
        check($sformatf("u%0d.end.busy", i),    32'(o.busy),    32'd0);
        check($sformatf("u%0d.end.vec_idx", i), 32'(o.vec_idx), 32'(nvec - 1));
    endtask

    task automatic push_toggle(input int n);
        for (int v = 0; v < n; v++) exp_q.push_back(4'(v % 2));
    endtask

    obs_t o;

    initial begin
        // Reset state
        repeat (3) tick();
        check_zero(0, "reset.u0");
        check_zero(2, "reset.u2");
        rst = 1'b0;
        tick();

        // WIDTH=1 toggle into an inverter: no mismatches, 90-cycle run
        mode = 2'b00; bufsel = '0;
        push_toggle(9);
        run(0, 10, 9, -1, -1, -1);
        check("u0.inv.err_cnt", 32'(ec0), 32'd0);
        check("u0.inv.err_flag", 32'(ef0), 32'd0);
        repeat (5) tick();
        o = observe(0);
        check("u0.done_hold.done",    32'(o.done),    32'd1);
        check("u0.done_hold.stim",    32'(o.stim),    32'd0);
        check("u0.done_hold.vec_idx", 32'(o.vec_idx), 32'd8);

        // Buffer DUT, restarted from DONE, start+mode change mid-run ignored
        mode = 2'b00; bufsel[0] = 1'b1;
        push_toggle(9);
        run(0, 10, 9, 3, -1, -1);
        check("u0.buf.err_cnt", 32'(ec0), 32'd9);
        check("u0.buf.err_flag", 32'(ef0), 32'd1);

        // Reset at vec_idx=4 aborts; restart runs all 9 vectors (walking-one is constant 1)
        mode = 2'b00; bufsel[0] = 1'b0;
        push_toggle(9);
        run(0, 10, 9, -1, 4, -1);
        repeat (2) tick();
        check_zero(0, "u0.after_abort");
        mode = 2'b01;
        for (int v = 0; v < 9; v++) exp_q.push_back(4'd1);
        run(0, 10, 9, -1, -1, -1);
        check("u0.restart.err_cnt", 32'(ec0), 32'd0);

        // WIDTH=4 walking-one and walking-zero
        mode = 2'b01;
        exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
        run(1, 2, 6, -1, -1, -1);
        check("u1.walk1.err_cnt", 32'(ec1), 32'd0);
        mode = 2'b11;
        exp_q = '{4'he, 4'hd, 4'hb, 4'h7, 4'he, 4'hd};
        run(1, 2, 6, -1, -1, -1);
        check("u1.walk0.err_cnt", 32'(ec1), 32'd0);

        // WIDTH=2 count wraps; ERRW=2 counter saturates with a buffer DUT
        mode = 2'b10; bufsel[2] = 1'b1;
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
        run(2, 1, 6, -1, -1, -1);
        check("u2.sat.err_cnt", 32'(ec2), 32'd3);
        check("u2.sat.err_flag", 32'(ef2), 32'd1);

        // HOLD=1: a mismatch on the last vector alone is still counted
        bufsel[2] = 1'b0;
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
        run(2, 1, 6, -1, -1, 5);
        check("u2.last.err_cnt", 32'(ec2), 32'd1);
        check("u2.last.err_flag", 32'(ef2), 32'd1);

        // Registered 3-stage inverter: LAT=3 matches, LAT=0 misses every vector
        mode = 2'b01;
        exp_q = '{4'h1, 4'h2, 4'h4, 4'h8};
        run(3, 5, 4, -1, -1, -1);
        check("u3.lat3.err_cnt", 32'(ec3), 32'd0);
        check("u3.lat3.err_flag", 32'(ef3), 32'd0);
        exp_q = '{4'h1, 4'h2, 4'h4, 4'h8};
        run(4, 5, 4, -1, -1, -1);
        check("u4.lat0.err_cnt", 32'(ec4), 32'd4);
        check("u4.lat0.err_flag", 32'(ef4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
